// File: rtl/agu_conv_gen_pkg.sv
// Shared PE package: mode encodings, AGU geometry defaults, the latched
// convolution configuration record and small beat helpers.
package agu_conv_gen_pkg;

   // PE operating modes
   typedef enum logic [0:0] {
      MODE_CONV = 1'b0,
      MODE_FC   = 1'b1
   } pe_mode_e;

   // Buffer geometry defaults
   localparam int ROW_SHIFT_DEF = 6;
   localparam int ADDR_W_DEF    = 8;

   // Convolution generator FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } conv_state_e;

   // Configuration captured on start_conv and held for the whole job
   typedef struct packed {
      logic [7:0] idx_cnt;
      logic       is_new;
      logic       pad_u;
      logic       pad_l;
      logic [5:0] lim_r;
      logic [5:0] lim_d;
   } conv_cfg_t;

   // A beat is padding when it sits on the padded top row or left column
   function automatic logic beat_is_pad(input logic pad_u, input logic pad_l,
                                        input logic row0,  input logic col0);
      return (pad_u && row0) || (pad_l && col0);
   endfunction

endpackage

// File: rtl/agu_win_cnt.sv
// Nested window counter: column (inner), row (middle), index (outer).
// Exposes the next counter values so the parent can register beat fields
// in the same edge the counters move, plus wrap and last-beat flags for
// the beat currently held.
module agu_win_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [5:0] lim_r,
   input  logic [5:0] lim_d,
   input  logic [7:0] idx_last,
   output logic [5:0] c_nxt,
   output logic [5:0] r_nxt,
   output logic [7:0] i_nxt,
   output logic       wrap_c,
   output logic       wrap_r,
   output logic       last
);

   logic [5:0] c_r;
   logic [5:0] r_r;
   logic [7:0] i_r;

   // Wrap/last flags of the current position and next-position arithmetic
   always_comb begin
      wrap_c = (c_r == lim_r);
      wrap_r = wrap_c && (r_r == lim_d);
      last   = wrap_r && (i_r == idx_last);
      c_nxt  = c_r;
      r_nxt  = r_r;
      i_nxt  = i_r;
      if (clr) begin
         c_nxt = 6'd0;
         r_nxt = 6'd0;
         i_nxt = 8'd0;
      end else if (en) begin
         if (wrap_c) begin
            c_nxt = 6'd0;
            if (wrap_r) begin
               r_nxt = 6'd0;
               i_nxt = i_r + 8'd1;
            end else begin
               r_nxt = r_r + 6'd1;
               i_nxt = i_r;
            end
         end else begin
            c_nxt = c_r + 6'd1;
            r_nxt = r_r;
            i_nxt = i_r;
         end
      end else begin
         c_nxt = c_r;
         r_nxt = r_r;
         i_nxt = i_r;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         c_r <= 6'd0;
         r_r <= 6'd0;
         i_r <= 8'd0;
      end else begin
         c_r <= c_nxt;
         r_r <= r_nxt;
         i_r <= i_nxt;
      end
   end

endmodule

// File: rtl/agu_conv_gen.sv
// Convolution-mode address generator. Walks a padded 2-D window per index
// and presents one registered input-buffer read address per beat on a
// valid/ready interface, finishing with a one-cycle done pulse.
module agu_conv_gen
   import agu_conv_gen_pkg::*;
#(
   parameter int ROW_SHIFT = ROW_SHIFT_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_conv,
   input  logic [7:0]        conf_idx_cnt,
   input  logic              conf_is_new,
   input  logic              conf_pad_u,
   input  logic              conf_pad_l,
   input  logic [5:0]        conf_lim_r,
   input  logic [5:0]        conf_lim_d,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_idx,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_pad,
   output logic              acc_clr,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   conv_state_e       state_r;
   conv_cfg_t         cfg_r;
   conv_cfg_t         conf_s;
   conv_cfg_t         cfg_use_s;

   logic              out_valid_r;
   logic [7:0]        out_idx_r;
   logic [ADDR_W-1:0] out_addr_r;
   logic              out_pad_r;
   logic              acc_clr_r;
   logic              out_last_r;
   logic              busy_r;
   logic              done_r;

   logic              start_acc_s;
   logic              hs_s;
   logic              cnt_en_s;

   logic [5:0]        c_nxt_s;
   logic [5:0]        r_nxt_s;
   logic [7:0]        i_nxt_s;
   logic              wrap_c_s;
   logic              wrap_r_s;
   logic              last_s;

   logic [5:0]        row_m_s;
   logic [5:0]        col_m_s;
   logic              col0_s;
   logic              pad_nxt_s;
   logic              acc_clr_nxt_s;
   logic              last_nxt_s;
   logic [ADDR_W-1:0] addr_nxt_s;

   assign conf_s = '{idx_cnt: conf_idx_cnt, is_new: conf_is_new,
                     pad_u: conf_pad_u, pad_l: conf_pad_l,
                     lim_r: conf_lim_r, lim_d: conf_lim_d};

   // Handshake and control qualifiers; a start is only honoured from IDLE
   always_comb begin
      start_acc_s = (state_r == ST_IDLE) && start_conv;
      hs_s        = out_valid_r && out_ready;
      cnt_en_s    = (state_r == ST_RUN) && hs_s;
      if (start_acc_s) begin
         cfg_use_s = conf_s;
      end else begin
         cfg_use_s = cfg_r;
      end
   end

   agu_win_cnt u_win_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_acc_s),
      .en       (cnt_en_s),
      .lim_r    (cfg_r.lim_r),
      .lim_d    (cfg_r.lim_d),
      .idx_last (cfg_r.idx_cnt - 8'd1),
      .c_nxt    (c_nxt_s),
      .r_nxt    (r_nxt_s),
      .i_nxt    (i_nxt_s),
      .wrap_c   (wrap_c_s),
      .wrap_r   (wrap_r_s),
      .last     (last_s)
   );

   // Fields of the beat that will be presented after the next load edge.
   // A load only happens on an accepted start or a handshake, so column 0
   // follows from a column wrap and the first beat of an index from a row
   // wrap (or a fresh start).
   always_comb begin
      col0_s        = start_acc_s || wrap_c_s;
      pad_nxt_s     = beat_is_pad(cfg_use_s.pad_u, cfg_use_s.pad_l,
                                  (r_nxt_s == 6'd0), col0_s);
      acc_clr_nxt_s = cfg_use_s.is_new && (start_acc_s || wrap_r_s);
      row_m_s       = r_nxt_s - {5'd0, cfg_use_s.pad_u};
      col_m_s       = c_nxt_s - {5'd0, cfg_use_s.pad_l};
      last_nxt_s    = (i_nxt_s == (cfg_use_s.idx_cnt - 8'd1)) &&
                      (r_nxt_s == cfg_use_s.lim_d) &&
                      (c_nxt_s == cfg_use_s.lim_r);
      if (pad_nxt_s) begin
         addr_nxt_s = {ADDR_W{1'b0}};
      end else begin
         addr_nxt_s = (ADDR_W'(row_m_s) << ROW_SHIFT) | ADDR_W'(col_m_s);
      end
   end

   // Control FSM with registered beat, busy and done outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cfg_r       <= {$bits(conv_cfg_t){1'b0}};
         out_valid_r <= 1'b0;
         out_idx_r   <= 8'd0;
         out_addr_r  <= {ADDR_W{1'b0}};
         out_pad_r   <= 1'b0;
         acc_clr_r   <= 1'b0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start_conv) begin
                  cfg_r <= conf_s;
                  if (conf_idx_cnt == 8'd0) begin
                     state_r <= ST_FIN;
                     done_r  <= 1'b1;
                  end else begin
                     state_r     <= ST_RUN;
                     busy_r      <= 1'b1;
                     out_valid_r <= 1'b1;
                     out_idx_r   <= i_nxt_s;
                     out_addr_r  <= addr_nxt_s;
                     out_pad_r   <= pad_nxt_s;
                     acc_clr_r   <= acc_clr_nxt_s;
                     out_last_r  <= last_nxt_s;
                  end
               end
            end
            ST_RUN: begin
               if (hs_s) begin
                  if (last_s) begin
                     state_r     <= ST_FIN;
                     out_valid_r <= 1'b0;
                     busy_r      <= 1'b0;
                     done_r      <= 1'b1;
                     out_idx_r   <= 8'd0;
                     out_addr_r  <= {ADDR_W{1'b0}};
                     out_pad_r   <= 1'b0;
                     acc_clr_r   <= 1'b0;
                     out_last_r  <= 1'b0;
                  end else begin
                     out_idx_r   <= i_nxt_s;
                     out_addr_r  <= addr_nxt_s;
                     out_pad_r   <= pad_nxt_s;
                     acc_clr_r   <= acc_clr_nxt_s;
                     out_last_r  <= last_nxt_s;
                  end
               end
            end
            ST_FIN: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign out_idx   = out_idx_r;
   assign out_addr  = out_addr_r;
   assign out_pad   = out_pad_r;
   assign acc_clr   = acc_clr_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_agu_conv_gen.sv
// Scoreboard bench for agu_conv_gen: a job-level reference model fills the
// expected-beat queue, a negedge monitor pops and compares on handshakes
// and checks stability during stalls.
module tb_agu_conv_gen;

   localparam int RS = 6;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_conv = 1'b0;
   logic [7:0]    conf_idx_cnt = 8'd0;
   logic          conf_is_new = 1'b0;
   logic          conf_pad_u = 1'b0;
   logic          conf_pad_l = 1'b0;
   logic [5:0]    conf_lim_r = 6'd0;
   logic [5:0]    conf_lim_d = 6'd0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [7:0]    out_idx;
   logic [AW-1:0] out_addr;
   logic          out_pad;
   logic          acc_clr;
   logic          out_last;
   logic          busy;
   logic          done;

   agu_conv_gen #(.ROW_SHIFT(RS), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start_conv(start_conv),
      .conf_idx_cnt(conf_idx_cnt), .conf_is_new(conf_is_new),
      .conf_pad_u(conf_pad_u), .conf_pad_l(conf_pad_l),
      .conf_lim_r(conf_lim_r), .conf_lim_d(conf_lim_d),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_addr(out_addr), .out_pad(out_pad), .acc_clr(acc_clr),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0]    idx;
      logic [AW-1:0] addr;
      logic          pad;
      logic          clr;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   beat_t cur_w;
   assign cur_w = {out_idx, out_addr, out_pad, acc_clr, out_last};

   int n_cmp = 0;
   int n_fail = 0;
   int last_hs_edge = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: enumerate the whole job from the window rules
   task automatic model_job(input int idx, input int isn, input int pu, input int pl,
                            input int lr, input int ld);
      beat_t b;
      int    a;
      for (int i = 0; i < idx; i++)
         for (int r = 0; r <= ld; r++)
            for (int c = 0; c <= lr; c++) begin
               b.idx  = 8'(i);
               b.pad  = ((pu != 0) && r == 0) || ((pl != 0) && c == 0);
               a      = b.pad ? 0 : ((r - pu) * (1 << RS) + (c - pl));
               b.addr = AW'(a);
               b.clr  = (isn != 0) && r == 0 && c == 0;
               b.last = (i == idx - 1) && (r == ld) && (c == lr);
               exp_q.push_back(b);
            end
   endtask

   // Monitor: compare on handshake, check hold while stalled
   logic  held = 1'b0;
   beat_t held_b;
   always @(negedge clk) begin
      if (!rst) begin
         held <= 1'b0;
      end else begin
         if (held) begin
            check("stall_valid_hold", 32'(out_valid), 32'd1);
            check("stall_fields_hold", 32'(cur_w), 32'(held_b));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_beat: got 0x%0h, expected no beat (cycle %0d)", cur_w, cyc);
            end else begin
               check("beat", 32'(cur_w), 32'(exp_q.pop_front()));
            end
            if (out_last) last_hs_edge <= cyc + 1;
            held <= 1'b0;
         end else if (out_valid) begin
            held   <= 1'b1;
            held_b <= cur_w;
         end else begin
            held <= 1'b0;
         end
      end
   end

   function automatic logic rdy(input int stall);
      return (stall == 0) ? 1'b1 : ($urandom_range(99) >= stall);
   endfunction

   task automatic scramble_conf();
      conf_idx_cnt = 8'($urandom_range(255));
      conf_is_new  = 1'($urandom_range(1));
      conf_pad_u   = 1'($urandom_range(1));
      conf_pad_l   = 1'($urandom_range(1));
      conf_lim_r   = 6'($urandom_range(63));
      conf_lim_d   = 6'($urandom_range(3));
   endtask

   task automatic run_job(input int idx, input int isn, input int pu, input int pl,
                          input int lr, input int ld, input int stall,
                          input bit restart_mid, input bit start_at_done);
      int beats;
      bit got_done;
      beats = idx * (ld + 1) * (lr + 1);
      model_job(idx, isn, pu, pl, lr, ld);
      @(posedge clk); #1;
      conf_idx_cnt = 8'(idx);
      conf_is_new  = 1'(isn);
      conf_pad_u   = 1'(pu);
      conf_pad_l   = 1'(pl);
      conf_lim_r   = 6'(lr);
      conf_lim_d   = 6'(ld);
      start_conv   = 1'b1;
      out_ready    = rdy(stall);
      @(posedge clk); #1;
      start_conv = 1'b0;
      scramble_conf();
      if (idx == 0) begin
         check("idx0_done", 32'(done), 32'd1);
         check("idx0_busy_valid", 32'({busy, out_valid}), 32'd0);
         @(posedge clk); #1;
         check("idx0_done_pulse", 32'({done, busy, out_valid}), 32'd0);
      end else begin
         check("start_busy_valid", 32'({busy, out_valid}), 32'd3);
         got_done = 1'b0;
         for (int k = 0; k < beats * 8 + 20 && !got_done; k++) begin
            out_ready  = rdy(stall);
            start_conv = (restart_mid && k == beats / 2) ? 1'b1 : 1'b0;
            if (start_conv) scramble_conf();
            @(posedge clk); #1;
            start_conv = 1'b0;
            if (done) got_done = 1'b1;
         end
         if (!got_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done after %0d beats", beats);
         end else begin
            check("done_after_last", 32'(cyc), 32'(last_hs_edge));
            check("fin_idle_outputs", 32'({busy, out_valid}), 32'd0);
            if (start_at_done) start_conv = 1'b1;
            @(posedge clk); #1;
            start_conv = 1'b0;
            check("post_done_idle", 32'({done, busy, out_valid}), 32'd0);
         end
      end
      check("beats_consumed", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      out_ready = 1'b0;
   endtask

   initial begin
      bit seen_done;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'({out_valid, busy, done, out_last, acc_clr, out_pad, out_addr, out_idx}), 32'd0);
      rst = 1'b1;

      // Directed jobs
      run_job(1, 0, 0, 0, 2, 1, 0, 1'b0, 1'b0);
      run_job(1, 0, 1, 1, 2, 2, 0, 1'b0, 1'b0);
      run_job(3, 1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      run_job(2, 1, 0, 1, 3, 2, 0, 1'b0, 1'b0);
      run_job(2, 1, 0, 1, 3, 2, 45, 1'b1, 1'b0);
      run_job(0, 1, 1, 1, 5, 3, 0, 1'b0, 1'b0);
      run_job(2, 0, 1, 0, 1, 1, 20, 1'b0, 1'b1);

      // Reset in the middle of a job
      model_job(4, 1, 1, 1, 3, 3);
      @(posedge clk); #1;
      conf_idx_cnt = 8'd4; conf_is_new = 1'b1; conf_pad_u = 1'b1;
      conf_pad_l = 1'b1; conf_lim_r = 6'd3; conf_lim_d = 6'd3;
      start_conv = 1'b1;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      start_conv = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_job_reset", 32'({out_valid, busy, done, out_last, acc_clr, out_pad, out_addr, out_idx}), 32'd0);
      rst = 1'b1;
      exp_q.delete();
      out_ready = 1'b0;
      seen_done = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done || out_valid || busy) seen_done = 1'b1;
      end
      check("no_done_after_reset", 32'(seen_done), 32'd0);
      run_job(1, 1, 1, 0, 2, 1, 0, 1'b0, 1'b0);

      // Randomised jobs
      for (int n = 0; n < 10; n++) begin
         int st;
         st = (n % 3) * 30;
         run_job(int'($urandom_range(3)), int'($urandom_range(1)), int'($urandom_range(1)),
                 int'($urandom_range(1)), int'($urandom_range(5)), int'($urandom_range(3)),
                 st, (n % 4) == 1, (n % 4) == 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
